// File: rtl/sht40_pkg.sv
// sht40_pkg: shared FSM states, master codes, CRC constants and byte slot map
package sht40_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CMD_REQ, S_CMD_BUSY, S_WAIT, S_RD_REQ, S_RD_BUSY, S_CHECK, S_RETRY, S_FAIL
  } state_t;
  localparam logic [2:0] MST_IDLE = 3'b000;
  localparam logic [2:0] MST_END  = 3'b110;
  localparam logic [7:0] CRC_POLY = 8'h31;
  localparam logic [7:0] CRC_INIT = 8'hFF;
  localparam int T_MSB   = 0;
  localparam int T_LSB   = 1;
  localparam int T_CRC   = 2;
  localparam int RH_MSB  = 3;
  localparam int RH_LSB  = 4;
  localparam int RH_CRC  = 5;
  localparam int N_BYTES = 6;
endpackage

// File: rtl/sht40_sequencer_if.sv
// sht40_sequencer_if: request/status bus between the sequencer and the I2C master
interface sht40_sequencer_if;
  logic       Processor_Ready;
  logic [6:0] Peripheral_Address;
  logic [7:0] Command_Data_Frames;
  logic       i2c_writes;
  logic [3:0] SHT_Reads;
  logic [2:0] Master_State_Out;
  logic [3:0] Bytes_Received;
  logic [7:0] Data_Received;
  modport master (
    output Processor_Ready, Peripheral_Address, Command_Data_Frames, i2c_writes, SHT_Reads,
    input  Master_State_Out, Bytes_Received, Data_Received
  );
  modport slave (
    input  Processor_Ready, Peripheral_Address, Command_Data_Frames, i2c_writes, SHT_Reads,
    output Master_State_Out, Bytes_Received, Data_Received
  );
endinterface

// File: rtl/sht40_crc8.sv
// sht40_crc8: combinational CRC-8 (poly 0x31, init 0xFF) over one 16-bit word, MSB first
module sht40_crc8
  import sht40_pkg::*;
(
  input  logic [15:0] i_data,
  output logic [7:0]  o_crc
);
  // Bit-serial CRC unrolled across all 16 data bits
  always_comb begin
    o_crc = CRC_INIT;
    for (int i = 15; i >= 0; i--)
      o_crc = {o_crc[6:0], 1'b0} ^ ((o_crc[7] ^ i_data[i]) ? CRC_POLY : 8'h00);
  end
endmodule

// File: rtl/sht40_sequencer.sv
// sht40_sequencer: issues SHT40 measure command, waits, reads six bytes, CRC-checks and retries
module sht40_sequencer
  import sht40_pkg::*;
#(
  parameter logic [6:0] SHT_ADDR  = 7'h44,
  parameter logic [7:0] MEAS_CMD  = 8'hFD,
  parameter int         MEAS_WAIT = 100000,
  parameter int         TIMEOUT   = 200000,
  parameter int         MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  sht40_sequencer_if.master  bus,
  output logic [15:0]        temp_raw,
  output logic [15:0]        rh_raw,
  output logic               meas_valid,
  output logic               busy,
  output logic               crc_fail,
  output logic               timeout_err,
  output logic               fail
);
  state_t      r_state, w_next;
  logic [31:0] r_tmo, r_wait, r_retry;
  logic [2:0]  r_idx;
  logic [3:0]  r_last;
  logic [7:0]  r_bytes [N_BYTES];
  logic [15:0] r_temp, r_rh;
  logic        r_valid, r_crc_fail, r_tmo_err, r_fail;
  logic [7:0]  w_crc_t, w_crc_h;
  logic        w_timed, w_tmo, w_good, w_mst_idle, w_can_retry, w_accept;
  sht40_crc8 u_crc_t (.i_data({r_bytes[T_MSB], r_bytes[T_LSB]}), .o_crc(w_crc_t));
  sht40_crc8 u_crc_h (.i_data({r_bytes[RH_MSB], r_bytes[RH_LSB]}), .o_crc(w_crc_h));
  assign w_timed     = r_state inside {S_CMD_REQ, S_CMD_BUSY, S_RD_REQ, S_RD_BUSY};
  assign w_tmo       = w_timed && r_tmo == 32'(TIMEOUT - 1);
  assign w_good      = r_idx == 3'(N_BYTES) && w_crc_t == r_bytes[T_CRC] && w_crc_h == r_bytes[RH_CRC];
  assign w_mst_idle  = bus.Master_State_Out == MST_IDLE;
  assign w_can_retry = r_retry < 32'(MAX_RETRY);
  assign w_accept    = r_state == S_IDLE && start;
  assign bus.Processor_Ready     = r_state == S_CMD_REQ || r_state == S_RD_REQ;
  assign bus.i2c_writes          = r_state == S_CMD_REQ || r_state == S_CMD_BUSY;
  assign bus.Peripheral_Address  = SHT_ADDR;
  assign bus.Command_Data_Frames = MEAS_CMD;
  assign bus.SHT_Reads           = 4'd6;
  assign busy        = r_state != S_IDLE;
  assign temp_raw    = r_temp;
  assign rh_raw      = r_rh;
  assign meas_valid  = r_valid;
  assign crc_fail    = r_crc_fail;
  assign timeout_err = r_tmo_err;
  assign fail        = r_fail;
  // Next-state decode; a transaction timeout overrides the normal handshake progress
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = start ? S_CMD_REQ : S_IDLE;
      S_CMD_REQ:  w_next = w_tmo ? S_RETRY : !w_mst_idle ? S_CMD_BUSY : S_CMD_REQ;
      S_CMD_BUSY: w_next = w_tmo ? S_RETRY : w_mst_idle ? S_WAIT : S_CMD_BUSY;
      S_WAIT:     w_next = r_wait + 1 >= 32'(MEAS_WAIT) ? S_RD_REQ : S_WAIT;
      S_RD_REQ:   w_next = w_tmo ? S_RETRY : !w_mst_idle ? S_RD_BUSY : S_RD_REQ;
      S_RD_BUSY:  w_next = w_tmo ? S_RETRY : w_mst_idle ? S_CHECK : S_RD_BUSY;
      S_CHECK:    w_next = w_good ? S_IDLE : S_RETRY;
      S_RETRY:    w_next = w_can_retry ? S_CMD_REQ : S_FAIL;
      default:    w_next = S_IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // Timeout counter restarts whenever a transaction phase begins; wait counter runs only in WAIT
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tmo  <= '0;
      r_wait <= '0;
    end else begin
      r_tmo  <= w_timed ? r_tmo + 1 : '0;
      r_wait <= r_state == S_WAIT ? r_wait + 1 : '0;
    end
  // Byte capture keyed on any change of the master byte counter, including wrap-around
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_idx  <= '0;
      r_last <= '0;
      for (int i = 0; i < N_BYTES; i++) r_bytes[i] <= '0;
    end else if (r_state != S_RD_REQ && w_next == S_RD_REQ) begin
      r_idx  <= '0;
      r_last <= bus.Bytes_Received;
    end else if (r_state == S_RD_BUSY && bus.Bytes_Received != r_last) begin
      r_last <= bus.Bytes_Received;
      if (r_idx < 3'(N_BYTES)) begin
        r_bytes[r_idx] <= bus.Data_Received;
        r_idx          <= r_idx + 3'd1;
      end
    end
  // Sticky error flags and retry count, cleared only by an accepted start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_crc_fail <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_fail     <= 1'b0;
      r_retry    <= '0;
    end else if (w_accept) begin
      r_crc_fail <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_fail     <= 1'b0;
      r_retry    <= '0;
    end else begin
      r_tmo_err  <= r_tmo_err | w_tmo;
      r_crc_fail <= r_crc_fail | (r_state == S_CHECK && !w_good);
      r_fail     <= r_fail | (r_state == S_RETRY && !w_can_retry);
      r_retry    <= r_retry + 32'(r_state == S_RETRY && w_can_retry);
    end
  // Result words load only on a clean CHECK, with a matching one-cycle valid pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_temp  <= '0;
      r_rh    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_state == S_CHECK && w_good;
      if (r_state == S_CHECK && w_good) begin
        r_temp <= {r_bytes[T_MSB], r_bytes[T_LSB]};
        r_rh   <= {r_bytes[RH_MSB], r_bytes[RH_LSB]};
      end
    end
endmodule

// File: doc/sht40_sequencer.md
SHT40_SEQUENCER -- requirements
Module: sht40_sequencer

Interface
REQ-001 Parameter SHT_ADDR, default 7'h44, 7-bit SHT40 device address.
REQ-002 Parameter MEAS_CMD, default 8'hFD, measurement command byte (high precision).
REQ-003 Parameter MEAS_WAIT, default 100000, number of clk cycles between command completion and read start.
REQ-004 Parameter TIMEOUT, default 200000, maximum number of clk cycles per I2C transaction.
REQ-005 Parameter MAX_RETRY, default 3, number of retries after a failure.
REQ-006 Ports: one clock; reset is asynchronous and active-high; clk input 1, system clock; rst input 1, async active-high reset.
REQ-007 start input 1: single-cycle request for one measurement; ignored while busy.
REQ-008 Master_State_Out input 3: master state code; 3'b000 = idle/processor, 3'b110 = end.
REQ-009 Bytes_Received input 4: master byte counter; increments by 1 per received byte.
REQ-010 Data_Received input 8: last received byte; valid when Bytes_Received changes.
REQ-011 Processor_Ready output 1: transaction request to the master.
REQ-012 Peripheral_Address output 7: constant SHT_ADDR.
REQ-013 Command_Data_Frames output 8: constant MEAS_CMD.
REQ-014 i2c_writes output 1: 1 for the command transaction, 0 for the read transaction.
REQ-015 SHT_Reads output 4: constant 4'd6.
REQ-016 temp_raw output 16 and rh_raw output 16: last good measurement words.
REQ-017 meas_valid output 1: one-cycle pulse when temp_raw/rh_raw update.
REQ-018 busy, crc_fail, timeout_err, fail: output 1 each; fail = retries exhausted.

Function
REQ-019 FSM states: IDLE, CMD_REQ, CMD_BUSY, WAIT, RD_REQ, RD_BUSY, CHECK, RETRY, FAIL.
REQ-020 IDLE: on start, clear crc_fail, timeout_err, fail and the retry count, then go to CMD_REQ.
REQ-021 CMD_REQ/RD_REQ: assert Processor_Ready.
  - Move to *_BUSY on the first cycle with Master_State_Out != 3'b000.
  - Deassert Processor_Ready in that same transition.
REQ-022 *_BUSY: the transaction completes on the first cycle with Master_State_Out == 3'b000.
  - CMD_BUSY then goes to WAIT.
  - RD_BUSY then goes to CHECK.
REQ-023 A single timeout counter runs in CMD_REQ, CMD_BUSY, RD_REQ and RD_BUSY.
  - It resets on entry to each *_REQ state.
  - When it reaches TIMEOUT: set timeout_err, deassert Processor_Ready, go to RETRY.
REQ-024 WAIT counts MEAS_WAIT cycles exactly, then goes to RD_REQ.
REQ-025 Byte capture during RD_BUSY:
  - Record Bytes_Received on RD_REQ entry.
  - Each change of Bytes_Received stores Data_Received into byte slot idx 0..5, then idx increments.
  - Captures beyond idx 5 are ignored.
REQ-026 Byte slot order: T_msb, T_lsb, T_crc, RH_msb, RH_lsb, RH_crc.
REQ-027 CRC: CRC-8, polynomial 0x31, init 0xFF, no final XOR, computed over each msb/lsb pair.
REQ-028 CHECK takes one cycle.
  - idx == 6 and both CRCs match: load temp_raw/rh_raw, pulse meas_valid, go to IDLE.
  - Otherwise: set crc_fail, go to RETRY.
REQ-029 RETRY: if retry count < MAX_RETRY, increment the count and go to CMD_REQ; otherwise set fail and go to FAIL.
REQ-030 FAIL goes to IDLE after one cycle; the error flags hold until the next accepted start.
REQ-031 busy = 1 in every state except IDLE.
REQ-032 A start input while busy is dropped, not queued.
REQ-033 Bytes_Received wrap-around (4'hF to 4'h0) counts as a change.

Reset
REQ-034 rst asynchronously forces:
  - state IDLE;
  - Processor_Ready, i2c_writes, meas_valid, busy, crc_fail, timeout_err, fail all 0;
  - temp_raw, rh_raw, idx, all counters 0.
REQ-035 A reset mid-transaction drops Processor_Ready immediately; the sequencer does not wait for the master to return to idle.

Structure
REQ-036 Package sht40_pkg SHALL hold:
  - the FSM state enum;
  - the master state codes (3'b000, 3'b110);
  - the CRC polynomial and init value;
  - the byte slot indices.
REQ-037 Sub-module sht40_crc8 SHALL be a combinational CRC-8 over 16 bits, instantiated twice (temperature, humidity).

Verification
REQ-038 The bench SHALL cover these scenarios with a master model that exits 3'b000 after 2 cycles and returns after 50 cycles:
  - Nominal: start; model supplies bytes 66 66 93 80 00 A2 (valid CRCs) -> temp_raw=16'h6666, rh_raw=16'h8000, meas_valid pulses once, busy=0.
  - CRC error: RH CRC byte A2 replaced by A3 -> crc_fail=1, command transaction reissued, retry count=1.
  - Timeout: model never leaves 3'b000 -> timeout_err=1 after TIMEOUT cycles; with MAX_RETRY=3, fail=1 after 4 attempts.
  - WAIT length: MEAS_WAIT=10 -> exactly 10 cycles from CMD_BUSY exit to Processor_Ready rise.
  - Dropped start: start pulsed while in WAIT -> no extra measurement; meas_valid pulses once in total.
  - Reset mid-read: rst asserted in RD_BUSY -> all outputs 0 in the same cycle; next start performs a clean measurement.
